// File: rtl/alu_iter_pkg.sv
// Shared ALU_INTERFACE / CPU_INTERNAL command codes and data width for the
// iterative ALU; the macros are the codebase-wide names, the package mirrors them.
`ifndef ALU_INTERFACE_DEFINES
`define ALU_INTERFACE_DEFINES
`define CD_N  32
`define AC_N  3
`define AC_AD 3'd0
`define AC_SB 3'd1
`define AC_ML 3'd2
`define AC_DV 3'd3
`define AC_RM 3'd4
`endif

package alu_iter_pkg;
   localparam int CD_N = `CD_N;
   localparam int AC_N = `AC_N;

   localparam logic [AC_N-1:0] AC_AD = `AC_AD;
   localparam logic [AC_N-1:0] AC_SB = `AC_SB;
   localparam logic [AC_N-1:0] AC_ML = `AC_ML;
   localparam logic [AC_N-1:0] AC_DV = `AC_DV;
   localparam logic [AC_N-1:0] AC_RM = `AC_RM;
endpackage

// File: rtl/alu_iter_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on magnitudes.
// Magnitudes never exceed 2**(W-1), so the trial difference sign sits in bit W.
module alu_iter_step
   import alu_iter_pkg::*;
#(
   parameter int W = `CD_N
) (
   input  logic         i_div,
   input  logic [W-1:0] i_acc,
   input  logic [W-1:0] i_opr,
   input  logic [W-1:0] i_m,
   output logic [W-1:0] o_acc,
   output logic [W-1:0] o_opr,
   output logic         o_bit
);

   logic [W:0] w_sum;
   logic [W:0] w_shift;
   logic [W:0] w_diff;

   always_comb begin
      w_sum   = {1'b0, i_acc} + {1'b0, (i_opr[0] ? i_m : '0)};
      w_shift = {i_acc, i_opr[W-1]};
      w_diff  = w_shift - {1'b0, i_m};
      if (i_div) begin
         // Quotient bit is 1 when the trial subtraction did not borrow.
         o_bit = ~w_diff[W];
         o_acc = o_bit ? w_diff[W-1:0] : w_shift[W-1:0];
         o_opr = {i_opr[W-2:0], 1'b0};
      end else begin
         // Product shifts right; the sum LSB becomes the next product bit.
         o_bit = w_sum[0];
         o_acc = w_sum[W:1];
         o_opr = {1'b0, i_opr[W-1:1]};
      end
   end

endmodule

// File: rtl/alu_iter.sv
// Iterative two's-complement ALU: one-cycle add/sub, W-step multiply/divide/remainder.
// Operands latch on start; a routing cycle precedes the W iteration cycles.
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int W     = `CD_N,
   parameter int CMD_W = `AC_N
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [W-1:0]     al_A,
   input  logic [W-1:0]     al_B,
   input  logic [CMD_W-1:0] al_cmd,
   input  logic             al_start,
   output logic             al_busy,
   output logic             al_done,
   output logic [W-1:0]     al_C,
   output logic             al_err,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_busy;
   logic             r_done;
   logic [W-1:0]     r_c;
   logic             r_err;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [CMD_W-1:0] r_cmd;
   logic [W-1:0]     r_acc;
   logic [W-1:0]     r_opr;
   logic [W-1:0]     r_m;
   logic [CNT_W-1:0] r_cnt;

   logic             w_is_ad, w_is_sb, w_is_ml, w_is_dv, w_is_rm;
   logic             w_b_zero, w_one_step, w_div;
   logic             w_sa, w_sb, w_neg;
   logic [W-1:0]     w_mag_a, w_mag_b;
   logic [W-1:0]     w_acc, w_opr_sh, w_opr;
   logic             w_bit;
   logic [W-1:0]     w_sum, w_dif;
   logic [2*W-1:0]   w_prod;
   logic             w_ml_ovf;
   logic             w_route, w_last;
   logic [W-1:0]     w_c_nxt;
   logic             w_err_nxt;

   assign w_is_ad    = (r_cmd == CMD_W'(AC_AD));
   assign w_is_sb    = (r_cmd == CMD_W'(AC_SB));
   assign w_is_ml    = (r_cmd == CMD_W'(AC_ML));
   assign w_is_dv    = (r_cmd == CMD_W'(AC_DV));
   assign w_is_rm    = (r_cmd == CMD_W'(AC_RM));
   assign w_b_zero   = (r_b == '0);
   assign w_one_step = !(w_is_ml || ((w_is_dv || w_is_rm) && !w_b_zero));
   assign w_div      = !w_is_ml;

   assign w_sa    = r_a[W-1];
   assign w_sb    = r_b[W-1];
   assign w_neg   = w_sa ^ w_sb;
   assign w_mag_a = w_sa ? -r_a : r_a;
   assign w_mag_b = w_sb ? -r_b : r_b;

   assign w_sum = r_a + r_b;
   assign w_dif = r_a - r_b;

   alu_iter_step #(.W(W)) u_step (
      .i_div (w_div),
      .i_acc (r_acc),
      .i_opr (r_opr),
      .i_m   (r_m),
      .o_acc (w_acc),
      .o_opr (w_opr_sh),
      .o_bit (w_bit)
   );

   assign w_opr = w_is_ml ? {w_bit, w_opr_sh[W-2:0]} : {w_opr_sh[W-1:1], w_bit};

   // After the last step: product = {acc, opr}; quotient = opr, remainder = acc.
   assign w_prod   = {w_acc, w_opr};
   assign w_ml_ovf = (w_prod[2*W-1:W] != '0) ||
                     (w_prod[W-1] && (!w_neg || (w_prod[W-2:0] != '0)));

   assign w_route = (r_state == RUN) && (r_cnt == '0);
   assign w_last  = (r_state == RUN) && (r_cnt == CNT_W'(1));

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_c     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (w_state_nxt == DONE);
         r_c     <= w_c_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (al_start) w_state_nxt = RUN;
         RUN:     if ((w_route && w_one_step) || w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Result and flag change only in the cycles that transition into DONE.
   always_comb begin
      w_c_nxt   = r_c;
      w_err_nxt = r_err;
      if (w_route && w_one_step) begin
         w_c_nxt   = '0;
         w_err_nxt = 1'b1;
         if (w_is_ad) begin
            w_c_nxt   = w_sum;
            w_err_nxt = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
         end else if (w_is_sb) begin
            w_c_nxt   = w_dif;
            w_err_nxt = (r_a[W-1] != r_b[W-1]) && (w_dif[W-1] != r_a[W-1]);
         end
      end else if (w_last) begin
         if (w_is_ml) begin
            w_c_nxt   = w_neg ? -w_prod[W-1:0] : w_prod[W-1:0];
            w_err_nxt = w_ml_ovf;
         end else if (w_is_dv) begin
            w_c_nxt   = w_neg ? -w_opr : w_opr;
            w_err_nxt = !w_neg && w_opr[W-1];
         end else begin
            w_c_nxt   = w_sa ? -w_acc : w_acc;
            w_err_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cmd <= '0;
         r_acc <= '0;
         r_opr <= '0;
         r_m   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (al_start) begin
                  r_a   <= al_A;
                  r_b   <= al_B;
                  r_cmd <= al_cmd;
               end
            end
            RUN: begin
               if (r_cnt == '0) begin
                  if (!w_one_step) begin
                     r_acc <= '0;
                     r_opr <= w_mag_a;
                     r_m   <= w_mag_b;
                     r_cnt <= CNT_W'(W);
                  end
               end else begin
                  r_acc <= w_acc;
                  r_opr <= w_opr;
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign al_busy     = r_busy;
   assign al_done     = r_done;
   assign al_C        = r_c;
   assign al_err      = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (W=32): latency, results and flags against
// hand-computed values, plus reset abort and start-ignore behaviour.
module tb_alu_iter;
   import alu_iter_pkg::*;

   localparam int W     = 32;
   localparam int CMD_W = AC_N;

   logic             clk = 1'b0;
   logic             Reset;
   logic [W-1:0]     al_A;
   logic [W-1:0]     al_B;
   logic [CMD_W-1:0] al_cmd;
   logic             al_start;
   logic             al_busy;
   logic             al_done;
   logic [W-1:0]     al_C;
   logic             al_err;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_err_q[$];

   always #5 clk = ~clk;

   alu_iter #(.W(W), .CMD_W(CMD_W)) dut (
      .Clock       (clk),
      .Reset       (Reset),
      .al_A        (al_A),
      .al_B        (al_B),
      .al_cmd      (al_cmd),
      .al_start    (al_start),
      .al_busy     (al_busy),
      .al_done     (al_done),
      .al_C        (al_C),
      .al_err      (al_err),
      .o_dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start one operation, scramble the inputs afterwards, and optionally
   // pulse al_start while the operation is running (poke_k > 0).
   task automatic do_op(input string tag, input logic [CMD_W-1:0] cmd,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_c, input logic exp_e,
                        input int exp_lat, input int poke_k);
      int k;
      exp_q.push_back(exp_c);
      exp_err_q.push_back(exp_e);
      @(negedge clk);
      al_A = a; al_B = b; al_cmd = cmd; al_start = 1'b1;
      @(negedge clk);
      al_start = 1'b0;
      al_A = $urandom; al_B = $urandom; al_cmd = CMD_W'($urandom_range(0, 7));
      check({tag, "/busy_at_start"}, al_busy, 1);
      k = 0;
      while (!al_done && k < 100) begin
         @(negedge clk);
         k++;
         al_start = (k == poke_k);
      end
      al_start = 1'b0;
      check({tag, "/latency"}, k, exp_lat);
      check({tag, "/C"}, al_C, exp_q.pop_front());
      check({tag, "/err"}, al_err, exp_err_q.pop_front());
      @(negedge clk);
      check({tag, "/done_one_cycle"}, al_done, 0);
      check({tag, "/busy_after"}, al_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done;
      Reset = 1'b0; al_start = 1'b0; al_A = '0; al_B = '0; al_cmd = '0;
      repeat (3) @(negedge clk);
      check("reset/busy", al_busy, 0);
      check("reset/done", al_done, 0);
      check("reset/C", al_C, 0);
      check("reset/err", al_err, 0);
      check("reset/state", dbg_state, 0);
      Reset = 1'b1;

      do_op("ad_7_m3", AC_AD, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0, 1, 0);
      do_op("ml_12_m5", AC_ML, 32'd12, 32'hFFFF_FFFB, 32'hFFFF_FFC4, 1'b0, W + 1, 5);
      do_op("dv_5_0", AC_DV, 32'd5, 32'd0, 32'd0, 1'b1, 1, 0);
      do_op("dv_100_7", AC_DV, 32'd100, 32'd7, 32'd14, 1'b0, W + 1, 0);
      do_op("rm_100_7", AC_RM, 32'd100, 32'd7, 32'd2, 1'b0, W + 1, 0);
      do_op("rm_m7_2", AC_RM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, W + 1, 0);
      do_op("dv_m100_7", AC_DV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, W + 1, 0);
      do_op("rm_m100_7", AC_RM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, W + 1, 0);
      do_op("dv_min_m1", AC_DV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, W + 1, 0);
      do_op("rm_min_m1", AC_RM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, W + 1, 0);
      do_op("rm_9_0", AC_RM, 32'd9, 32'd0, 32'd0, 1'b1, 1, 0);
      do_op("ad_ovf", AC_AD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1, 0);
      do_op("sb_ovf", AC_SB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1, 0);
      do_op("sb_5_9", AC_SB, 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b0, 1, 0);
      do_op("ml_m7_m6", AC_ML, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd42, 1'b0, W + 1, 0);
      do_op("ml_big_ovf", AC_ML, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, W + 1, 0);
      do_op("ml_min_fit", AC_ML, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, W + 1, 0);
      do_op("ml_min_m1", AC_ML, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, W + 1, 0);
      do_op("unknown_cmd", CMD_W'(7), 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
      do_op("ad_pre_abort", AC_AD, 32'd20, 32'd3, 32'd23, 1'b0, 1, 0);

      // Reset in the 10th RUN cycle of a multiply aborts it.
      @(negedge clk);
      al_A = 32'd3; al_B = 32'd4; al_cmd = AC_ML; al_start = 1'b1;
      @(negedge clk);
      al_start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort/busy_before", al_busy, 1);
      Reset = 1'b0;
      @(negedge clk);
      check("abort/busy", al_busy, 0);
      check("abort/C", al_C, 0);
      check("abort/done", al_done, 0);
      check("abort/state", dbg_state, 0);
      Reset = 1'b1;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (al_done) saw_done = 1'b1;
      end
      check("abort/no_done_later", saw_done, 0);
      do_op("ad_1_1_after_abort", AC_AD, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      Reset = 1'b0; al_start = 1'b1; al_cmd = AC_AD; al_A = 32'd1; al_B = 32'd2;
      @(negedge clk);
      Reset = 1'b1; al_start = 1'b0;
      check("rst_prio/busy", al_busy, 0);
      check("rst_prio/C", al_C, 0);
      @(negedge clk);
      check("rst_prio/busy_next", al_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter: W, `CD_N, operand/result width in bits; two's complement.
REQ-002 SHALL have parameter: CMD_W, `AC_N, command width.
REQ-003 SHALL have port: Clock  in  1  rising-edge clock.
REQ-004 SHALL have port: Reset  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port: al_A  in  W  operand A (dividend, minuend).
REQ-006 SHALL have port: al_B  in  W  operand B (divisor, subtrahend).
REQ-007 SHALL have port: al_cmd  in  CMD_W  operation: AC_AD, AC_SB, AC_ML, AC_DV, AC_RM.
REQ-008 SHALL have port: al_start  in  1  request; sampled only in IDLE.
REQ-009 SHALL have port: al_busy  out  1  high in RUN and DONE.
REQ-010 SHALL have port: al_done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: al_C  out  W  result; held from done until next completion.
REQ-012 SHALL have port: al_err  out  1  error/overflow flag; valid with al_C.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE, with registered outputs.
REQ-014 In IDLE with al_start=1, SHALL latch al_A, al_B and al_cmd in that cycle; later input changes have no effect.
REQ-015 Routing after the start cycle:
- AC_AD, AC_SB, divide-by-zero, unknown cmd: next state DONE.
- AC_ML, AC_DV, AC_RM: next state RUN, iteration counter loaded with W.
REQ-016 In RUN, SHALL perform one shift-add (ML) or restoring-subtract (DV/RM) step per cycle on operand magnitudes and decrement the counter; at count 1, next state DONE.
REQ-017 Latency, start sampled at edge t:
- al_done high in the cycle after edge t+1 for the 1-step group of REQ-015.
- al_done high in the cycle after edge t+W+1 for ML/DV/RM.
REQ-018 In DONE, al_done=1 for exactly one cycle; then return to IDLE. al_start in RUN or DONE SHALL be ignored and not queued.
REQ-019 AD/SB: result is sum/difference modulo 2^W; al_err=1 on signed overflow.
REQ-020 ML: magnitude product with sign = sign(A) xor sign(B); al_C = low W bits; al_err=1 if the signed result does not fit in W bits.
REQ-021 DV: quotient truncated toward zero. RM: remainder with the sign of A, |C| < |B|. Most-negative / -1 SHALL give C=A, err=1 for DV, and C=0, err=0 for RM.
REQ-022 B=0 for DV/RM SHALL give C=0 and err=1; unknown cmd SHALL give C=0 and err=1.
REQ-023 al_C/al_err SHALL update only on entry to DONE.

Reset
REQ-024 Reset=0 at a rising edge SHALL force IDLE, al_C=0, al_err=0, al_done=0, al_busy=0, counter=0, and clear the latched operands.
REQ-025 Reset during RUN or DONE SHALL abort the operation: no al_done pulse, and al_C SHALL read 0.
REQ-026 Reset takes priority over al_start in the same cycle.

Structure
REQ-027 AC_* codes, AC_N and CD_N SHALL come from the shared ALU_INTERFACE/CPU_INTERNAL defines; state encodings are local to alu_iter.
REQ-028 One combinational sub-module, alu_iter_step, SHALL compute one shift-add or restoring-subtract iteration (partial remainder/accumulator, shifted operand, next bit).
REQ-029 Sign handling (magnitude in, sign fix-up out) SHALL remain in alu_iter.

Verification (W=32)
REQ-030 AD 7,-3 at edge t: done at t+1, C=4, err=0; busy low at t+2.
REQ-031 ML 12,-5: done exactly W+1 cycles after start, C=-60, err=0; al_start pulsed mid-RUN has no effect.
REQ-032 Division cases:
- DV 100,7 -> C=14.
- RM 100,7 -> C=2.
- RM -7,2 -> C=-1.
- DV 0x80000000,-1 -> C=0x80000000, err=1.
REQ-033 DV 5,0: done at t+1, C=0, err=1; prior C not visible at done.
REQ-034 AD 0x7FFFFFFF,1 -> C=0x80000000, err=1; SB 0x80000000,1 -> C=0x7FFFFFFF, err=1.
REQ-035 Reset=0 on the 10th RUN cycle of ML: next cycle busy=0, C=0, and no done pulse; a new AD 1,1 then completes normally with C=2.
